// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Multi-cycle control unit for an RV32I-subset CPU
//            (JAL, BEQ, LW, SW, ADDI, ADD). Sequences the shared datapath
//            through fetch, decode, execute, memory and write-back, drives a
//            single-port memory via req/ack, and halts in a sticky trap on
//            an unsupported opcode.
// Ports    : clk, rst (async, active-high), run, opcode[6:0], alu_zero,
//            mem_ack                                         -- inputs
//            mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, oldpc_we,
//            alu_a_sel[1:0], alu_b_sel[1:0], alu_op[1:0], reg_we,
//            wb_sel[1:0], mdr_we, trap, state[3:0],
//            cycle_cnt[31:0], instr_cnt[31:0]                -- outputs
// Config   : CTRL_PERF_EN -- when defined, builds the cycle and instruction
//            performance counters; otherwise both counter ports read 0.
// Revision : 1.0  initial release
// ============================================================================
module mc_control (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [6:0]  opcode,
   input  logic        alu_zero,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_src,
   output logic        oldpc_we,
   output logic [1:0]  alu_a_sel,
   output logic [1:0]  alu_b_sel,
   output logic [1:0]  alu_op,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        mdr_we,
   output logic        trap,
   output logic [3:0]  state,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FETCH   = 4'd1;
   localparam logic [3:0] S_DECODE  = 4'd2;
   localparam logic [3:0] S_EX_ADDR = 4'd3;
   localparam logic [3:0] S_EX_R    = 4'd4;
   localparam logic [3:0] S_EX_I    = 4'd5;
   localparam logic [3:0] S_MEM_RD  = 4'd6;
   localparam logic [3:0] S_MEM_WR  = 4'd7;
   localparam logic [3:0] S_WB_ALU  = 4'd8;
   localparam logic [3:0] S_WB_MEM  = 4'd9;
   localparam logic [3:0] S_BRANCH  = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;
   localparam logic [3:0] S_TRAP    = 4'd12;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_ADD  = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic [3:0] boundary_state;

   // Where an instruction goes once it retires.
   assign boundary_state = run ? S_FETCH : S_IDLE;
   assign state          = state_q;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (run) state_d = S_FETCH;
         S_FETCH:   if (mem_ack) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_EX_ADDR;
               OP_ADD:       state_d = S_EX_R;
               OP_ADDI:      state_d = S_EX_I;
               OP_BEQ:       state_d = S_BRANCH;
               OP_JAL:       state_d = S_JUMP;
               default:      state_d = S_TRAP;
            endcase
         end
         S_EX_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_EX_R:    state_d = S_WB_ALU;
         S_EX_I:    state_d = S_WB_ALU;
         S_MEM_RD:  if (mem_ack) state_d = S_WB_MEM;
         S_MEM_WR:  if (mem_ack) state_d = boundary_state;
         S_WB_ALU:  state_d = boundary_state;
         S_WB_MEM:  state_d = boundary_state;
         S_BRANCH:  state_d = boundary_state;
         S_JUMP:    state_d = boundary_state;
         S_TRAP:    state_d = S_TRAP;
         // Unused encodings can only arise from an upset; halt visibly.
         default:   state_d = S_TRAP;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 1'b0;
      oldpc_we     = 1'b0;
      alu_a_sel    = 2'd0;
      alu_b_sel    = 2'd0;
      alu_op       = 2'd0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
      mdr_we       = 1'b0;
      trap         = 1'b0;
      case (state_q)
         S_FETCH: begin
            // PC + 4 through the ALU; OldPC captures the pre-increment PC
            // on the same edge that loads IR and the new PC.
            mem_req   = 1'b1;
            alu_b_sel = 2'd1;
            ir_we     = mem_ack;
            pc_we     = mem_ack;
            oldpc_we  = mem_ack;
         end
         S_DECODE: begin
            // OldPC + imm lands in ALU-out as the branch/jump target.
            alu_a_sel = 2'd1;
            alu_b_sel = 2'd2;
         end
         S_EX_ADDR, S_EX_I: begin
            alu_a_sel = 2'd2;
            alu_b_sel = 2'd2;
         end
         S_EX_R: begin
            alu_a_sel = 2'd2;
         end
         S_MEM_RD: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mdr_we       = mem_ack;
         end
         S_MEM_WR: begin
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            mem_addr_sel = 1'b1;
         end
         S_WB_ALU: begin
            reg_we = 1'b1;
         end
         S_WB_MEM: begin
            reg_we = 1'b1;
            wb_sel = 2'd1;
         end
         S_BRANCH: begin
            // rs1 - rs2 sets alu_zero; taken branch loads target from ALU-out.
            alu_a_sel = 2'd2;
            alu_op    = 2'd1;
            pc_src    = 1'b1;
            pc_we     = alu_zero;
         end
         S_JUMP: begin
            // PC already holds OldPC + 4, which is the link value for rd.
            reg_we = 1'b1;
            wb_sel = 2'd2;
            pc_we  = 1'b1;
            pc_src = 1'b1;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: ;
      endcase
   end

   // ----------------------------------------------------- performance counters
`ifdef CTRL_PERF_EN
   logic [31:0] cycle_cnt_q;
   logic [31:0] cycle_cnt_d;
   logic [31:0] instr_cnt_q;
   logic [31:0] instr_cnt_d;
   logic        retire;

   // An instruction retires on any transition to the boundary.
   assign retire = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
                   (state_q == S_BRANCH) || (state_q == S_JUMP)   ||
                   ((state_q == S_MEM_WR) && mem_ack);

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if ((state_q != S_IDLE) && (state_q != S_TRAP)) begin
         cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
      if (retire) begin
         instr_cnt_d = instr_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_q <= 32'd0;
         instr_cnt_q <= 32'd0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`else
   assign cycle_cnt = 32'd0;
   assign instr_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Randomized self-checking bench for mc_control. A queue-based
//            instruction-level model predicts state, control outputs and
//            performance counters every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_control;

   localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EX_ADDR = 3;
   localparam int ST_EX_R = 4, ST_EX_I = 5, ST_MEM_RD = 6, ST_MEM_WR = 7;
   localparam int ST_WB_ALU = 8, ST_WB_MEM = 9, ST_BRANCH = 10, ST_JUMP = 11;
   localparam int ST_TRAP = 12;
   localparam int N_CYCLES = 6000;
`ifdef CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, run, alu_zero, mem_ack;
   logic [6:0]  opcode;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, oldpc_we;
   logic [1:0]  alu_a_sel, alu_b_sel, alu_op, wb_sel;
   logic        reg_we, mdr_we, trap;
   logic [3:0]  state;
   logic [31:0] cycle_cnt, instr_cnt;

   mc_control dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .alu_zero(alu_zero),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
      .pc_src(pc_src), .oldpc_we(oldpc_we), .alu_a_sel(alu_a_sel),
      .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we),
      .wb_sel(wb_sel), .mdr_we(mdr_we), .trap(trap), .state(state),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
   endtask

   // ------------------------------------------------------------------ model
   int          m_state;
   int          plan[$];
   logic [31:0] m_cyc, m_ins;
   bit          need_op;

   // Expected control vector for a state, packed in a fixed field order.
   function automatic logic [17:0] exp_outs(int s, logic ack, logic z);
      logic req = 0, we = 0, asel = 0, irw = 0, pcw = 0, psrc = 0, opw = 0;
      logic regw = 0, mdrw = 0, trp = 0;
      logic [1:0] a = 0, b = 0, op = 0, wb = 0;
      case (s)
         ST_FETCH:   begin req = 1; b = 1; irw = ack; pcw = ack; opw = ack; end
         ST_DECODE:  begin a = 1; b = 2; end
         ST_EX_ADDR: begin a = 2; b = 2; end
         ST_EX_R:    begin a = 2; b = 0; end
         ST_EX_I:    begin a = 2; b = 2; end
         ST_MEM_RD:  begin req = 1; asel = 1; mdrw = ack; end
         ST_MEM_WR:  begin req = 1; we = 1; asel = 1; end
         ST_WB_ALU:  begin regw = 1; end
         ST_WB_MEM:  begin regw = 1; wb = 1; end
         ST_BRANCH:  begin a = 2; op = 1; psrc = 1; pcw = z; end
         ST_JUMP:    begin regw = 1; wb = 2; pcw = 1; psrc = 1; end
         ST_TRAP:    begin trp = 1; end
         default: ;
      endcase
      return {req, we, asel, irw, pcw, psrc, opw, a, b, op, regw, wb, mdrw, trp};
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int  nxt = m_state;
      bit  retire = 0;
      case (m_state)
         ST_IDLE:  if (run) nxt = ST_FETCH;
         ST_FETCH: if (mem_ack) nxt = ST_DECODE;
         ST_TRAP:  nxt = ST_TRAP;
         ST_DECODE: begin
            plan.delete();
            case (opcode)
               7'b0000011: plan = '{ST_EX_ADDR, ST_MEM_RD, ST_WB_MEM};
               7'b0100011: plan = '{ST_EX_ADDR, ST_MEM_WR};
               7'b0110011: plan = '{ST_EX_R, ST_WB_ALU};
               7'b0010011: plan = '{ST_EX_I, ST_WB_ALU};
               7'b1100011: plan = '{ST_BRANCH};
               7'b1101111: plan = '{ST_JUMP};
               default:    plan = '{ST_TRAP};
            endcase
            nxt = plan.pop_front();
         end
         default: begin
            if ((m_state == ST_MEM_RD || m_state == ST_MEM_WR) && !mem_ack)
               nxt = m_state;
            else if (plan.size() > 0)
               nxt = plan.pop_front();
            else begin
               retire = 1;
               nxt = run ? ST_FETCH : ST_IDLE;
            end
         end
      endcase
      if (m_state != ST_IDLE && m_state != ST_TRAP) m_cyc++;
      if (retire) m_ins++;
      if (nxt == ST_FETCH && m_state != ST_FETCH) need_op = 1;
      m_state = nxt;
   endtask

   task automatic model_reset();
      m_state = ST_IDLE;
      plan.delete();
      m_cyc   = 0;
      m_ins   = 0;
      need_op = 1;
   endtask

   function automatic logic [6:0] pick_opcode();
      int r = $urandom_range(0, 99);
      logic [6:0] o;
      if (r < 16)      o = 7'b0000011;
      else if (r < 32) o = 7'b0100011;
      else if (r < 48) o = 7'b0110011;
      else if (r < 64) o = 7'b0010011;
      else if (r < 80) o = 7'b1100011;
      else if (r < 97) o = 7'b1101111;
      else begin
         o = 7'($urandom);
         if (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
             o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111 ||
             $urandom_range(0, 1) == 0)
            o = 7'h7F;
      end
      return o;
   endfunction

   function automatic logic [17:0] obs_outs();
      return {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, oldpc_we,
              alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, mdr_we, trap};
   endfunction

   // Assert reset mid-cycle and confirm it acts without waiting for a clock.
   task automatic async_reset_check(input string tag);
      #1 rst = 1'b1;
      #1;
      check({tag, "_state"}, state, 0);
      check({tag, "_outs"}, obs_outs(), 0);
      check({tag, "_cyc"}, cycle_cnt, 0);
      check({tag, "_ins"}, instr_cnt, 0);
      model_reset();
   endtask

   // --------------------------------------------------------------- stimulus
   int trap_cycles;
   int wr_waits;

   initial begin
      rst = 1'b1; run = 1'b0; alu_zero = 1'b0; mem_ack = 1'b0;
      opcode = 7'b0110011;
      model_reset();
      trap_cycles = 0;
      wr_waits    = 0;
      #1;
      check("reset_state", state, 0);
      check("reset_outs", obs_outs(), 0);
      check("reset_cyc", cycle_cnt, 0);
      check("reset_ins", instr_cnt, 0);
      repeat (2) @(negedge clk);

      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(negedge clk);
         rst      = 1'b0;
         run      = ($urandom_range(0, 9) < 8);
         mem_ack  = ($urandom_range(0, 9) < 6);
         alu_zero = 1'($urandom);
         if (need_op) begin
            opcode  = pick_opcode();
            need_op = 0;
         end
         #1;
         check("state", state, m_state);
         check("outs", obs_outs(), exp_outs(m_state, mem_ack, alu_zero));
         check("cycle_cnt", cycle_cnt, PERF ? m_cyc : 32'd0);
         check("instr_cnt", instr_cnt, PERF ? m_ins : 32'd0);

         if (m_state == ST_TRAP) begin
            trap_cycles++;
            if (trap_cycles == 100) begin
               trap_cycles = 0;
               async_reset_check("trap_rst");
            end else model_step();
         end else if (m_state == ST_MEM_WR && !mem_ack && (++wr_waits % 3 == 0)) begin
            async_reset_check("memwr_rst");
         end else begin
            model_step();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
